// File: rtl/branch_resolve.sv
// Control-flow resolution in EX: outcome, target, link value and fetch redirect handshake.
// Optional statistics counters are enabled with `define BRANCH_STATS_EN.
module branch_resolve #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [1:0]       ex_kind,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic             cmp_res,
  input  logic             ex_pred_taken,
  output logic             res_valid,
  output logic             res_taken,
  output logic [XLEN-1:0]  link_data,
  output logic             flush,
  output logic             redir_valid,
  output logic [XLEN-1:0]  redir_pc,
  input  logic             redir_ready,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispred
);

  localparam logic [1:0] K_BR   = 2'b00;
  localparam logic [1:0] K_JAL  = 2'b01;
  localparam logic [1:0] K_JALR = 2'b10;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t          r_state;
  logic            r_ex_ready;
  logic            r_res_valid;
  logic            r_res_taken;
  logic [XLEN-1:0] r_link_data;
  logic            r_flush;
  logic            r_redir_valid;
  logic [XLEN-1:0] r_redir_pc;

  logic            w_accept;
  logic            w_taken;
  logic            w_mispred;
  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_next;
  logic [XLEN-1:0] w_link;

  assign w_accept = ex_valid && r_ex_ready;
  assign w_pc4    = ex_pc + XLEN'(4);

  always_comb begin
    w_taken  = 1'b0;
    w_target = ex_pc + ex_imm;
    w_link   = '0;
    case (ex_kind)
      K_BR:   w_taken = cmp_res;
      K_JAL: begin
        w_taken = 1'b1;
        w_link  = w_pc4;
      end
      K_JALR: begin
        w_taken  = 1'b1;
        w_target = (ex_rs1 + ex_imm) & {{(XLEN-1){1'b1}}, 1'b0};
        w_link   = w_pc4;
      end
      default: w_taken = 1'b0;
    endcase
  end

  assign w_next    = w_taken ? w_target : w_pc4;
  assign w_mispred = (w_taken != ex_pred_taken) || (ex_kind == K_JALR);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_ex_ready    <= 1'b1;
      r_res_valid   <= 1'b0;
      r_res_taken   <= 1'b0;
      r_link_data   <= '0;
      r_flush       <= 1'b0;
      r_redir_valid <= 1'b0;
      r_redir_pc    <= '0;
    end else begin
      r_res_valid <= w_accept;
      r_flush     <= w_accept && w_mispred;
      if (w_accept) begin
        r_res_taken <= w_taken;
        r_link_data <= w_link;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_mispred) begin
            r_state       <= S_HOLD;
            r_ex_ready    <= 1'b0;
            r_redir_valid <= 1'b1;
            r_redir_pc    <= w_next;
          end
        end
        S_HOLD: begin
          // redir_pc stays frozen until fetch takes it
          if (redir_ready) begin
            r_state       <= S_IDLE;
            r_ex_ready    <= 1'b1;
            r_redir_valid <= 1'b0;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_ex_ready    <= 1'b1;
          r_redir_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ex_ready    = r_ex_ready;
  assign res_valid   = r_res_valid;
  assign res_taken   = r_res_taken;
  assign link_data   = r_link_data;
  assign flush       = r_flush;
  assign redir_valid = r_redir_valid;
  assign redir_pc    = r_redir_pc;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] r_stat_branches;
  logic [CNT_W-1:0] r_stat_mispred;

  // saturating counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stat_branches <= '0;
      r_stat_mispred  <= '0;
    end else if (w_accept) begin
      if (r_stat_branches != '1) r_stat_branches <= r_stat_branches + CNT_W'(1);
      if (w_mispred && (r_stat_mispred != '1)) r_stat_mispred <= r_stat_mispred + CNT_W'(1);
    end
  end

  assign stat_branches = r_stat_branches;
  assign stat_mispred  = r_stat_mispred;
`else
  assign stat_branches = '0;
  assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed, table-driven bench for branch_resolve plus hand-written hold/reset/stats sequences.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ex_valid;
  logic        ex_ready;
  logic [1:0]  ex_kind;
  logic [63:0] ex_pc, ex_imm, ex_rs1;
  logic        cmp_res, ex_pred_taken;
  logic        res_valid, res_taken;
  logic [63:0] link_data;
  logic        flush, redir_valid;
  logic [63:0] redir_pc;
  logic        redir_ready;
  logic [31:0] stat_branches, stat_mispred;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  branch_resolve #(.XLEN(64), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_kind(ex_kind),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .cmp_res(cmp_res), .ex_pred_taken(ex_pred_taken),
    .res_valid(res_valid), .res_taken(res_taken), .link_data(link_data),
    .flush(flush), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .redir_ready(redir_ready),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  typedef struct {
    logic [1:0]  kind;
    logic [63:0] pc, imm, rs1;
    logic        cmp, pred;
    logic        e_taken;
    logic [63:0] e_link;
    logic        e_mis;
    logic [63:0] e_redir;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [1:0] k, input logic [63:0] pc, input logic [63:0] imm,
                       input logic [63:0] rs1, input logic c, input logic p);
    ex_valid      = 1'b1;
    ex_kind       = k;
    ex_pc         = pc;
    ex_imm        = imm;
    ex_rs1        = rs1;
    cmp_res       = c;
    ex_pred_taken = p;
  endtask

  task automatic handshake(input string nm);
    redir_ready = 1'b1;
    tick();
    redir_ready = 1'b0;
    chk({nm, ".redir_valid_drop"}, 64'(redir_valid), 64'd0);
    chk({nm, ".ex_ready_back"}, 64'(ex_ready), 64'd1);
  endtask

  initial begin
    //           kind   pc                     imm                    rs1       cmp  pred tkn link       mis redir
    vecs[0] = '{2'd0, 64'h1000,              64'h40,                64'h0,    1'b1, 1'b1, 1'b1, 64'h0,    1'b0, 64'h0};
    vecs[1] = '{2'd0, 64'h1000,              64'h40,                64'h0,    1'b0, 1'b0, 1'b0, 64'h0,    1'b0, 64'h0};
    vecs[2] = '{2'd0, 64'h1000,              64'h40,                64'h0,    1'b1, 1'b0, 1'b1, 64'h0,    1'b1, 64'h1040};
    vecs[3] = '{2'd1, 64'h2000,              64'h100,               64'h0,    1'b0, 1'b1, 1'b1, 64'h2004, 1'b0, 64'h0};
    vecs[4] = '{2'd2, 64'h3000,              64'h10,                64'h2003, 1'b0, 1'b1, 1'b1, 64'h3004, 1'b1, 64'h2012};
    vecs[5] = '{2'd1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8,               64'h0,    1'b0, 1'b0, 1'b1, 64'h0,    1'b1, 64'h4};
    vecs[6] = '{2'd3, 64'h500,               64'h20,                64'h0,    1'b1, 1'b0, 1'b0, 64'h0,    1'b0, 64'h0};
    vecs[7] = '{2'd3, 64'h500,               64'h20,                64'h0,    1'b1, 1'b1, 1'b0, 64'h0,    1'b1, 64'h504};
    vecs[8] = '{2'd0, 64'h1000,              64'hFFFF_FFFF_FFFF_FFF0, 64'h0,  1'b1, 1'b0, 1'b1, 64'h0,    1'b1, 64'hFF0};
    vecs[9] = '{2'd2, 64'h10,                64'h7,                 64'h0,    1'b0, 1'b0, 1'b1, 64'h14,   1'b1, 64'h6};

    rstn = 1'b0; ex_valid = 1'b0; ex_kind = 2'd0; ex_pc = '0; ex_imm = '0; ex_rs1 = '0;
    cmp_res = 1'b0; ex_pred_taken = 1'b0; redir_ready = 1'b0;
    #12;
    chk("rst.ex_ready", 64'(ex_ready), 64'd1);
    chk("rst.res_valid", 64'(res_valid), 64'd0);
    chk("rst.flush", 64'(flush), 64'd0);
    chk("rst.redir_valid", 64'(redir_valid), 64'd0);
    chk("rst.redir_pc", redir_pc, 64'd0);
    chk("rst.link_data", link_data, 64'd0);
    chk("rst.stat_branches", 64'(stat_branches), 64'd0);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].kind, vecs[i].pc, vecs[i].imm, vecs[i].rs1, vecs[i].cmp, vecs[i].pred);
      tick();
      ex_valid = 1'b0;
      chk($sformatf("v%0d.res_valid", i), 64'(res_valid), 64'd1);
      chk($sformatf("v%0d.res_taken", i), 64'(res_taken), 64'(vecs[i].e_taken));
      chk($sformatf("v%0d.link_data", i), link_data, vecs[i].e_link);
      chk($sformatf("v%0d.flush", i), 64'(flush), 64'(vecs[i].e_mis));
      chk($sformatf("v%0d.redir_valid", i), 64'(redir_valid), 64'(vecs[i].e_mis));
      chk($sformatf("v%0d.ex_ready", i), 64'(ex_ready), 64'(!vecs[i].e_mis));
      if (vecs[i].e_mis) begin
        chk($sformatf("v%0d.redir_pc", i), redir_pc, vecs[i].e_redir);
        handshake($sformatf("v%0d", i));
      end
    end

    // back-to-back correctly predicted, one per cycle
    apply(2'd0, 64'h100, 64'h8, 64'h0, 1'b1, 1'b1);
    tick();
    chk("b2b.first_valid", 64'(res_valid), 64'd1);
    apply(2'd1, 64'h200, 64'h8, 64'h0, 1'b0, 1'b1);
    tick();
    ex_valid = 1'b0;
    chk("b2b.second_valid", 64'(res_valid), 64'd1);
    chk("b2b.second_link", link_data, 64'h204);
    tick();
    chk("b2b.idle_valid", 64'(res_valid), 64'd0);

    // redir_ready while idle does nothing
    redir_ready = 1'b1;
    tick();
    redir_ready = 1'b0;
    chk("idle_rdy.redir_valid", 64'(redir_valid), 64'd0);
    chk("idle_rdy.ex_ready", 64'(ex_ready), 64'd1);

    // mispredict held for 3 cycles, ex_valid ignored
    apply(2'd0, 64'h1000, 64'h40, 64'h0, 1'b0, 1'b1);
    tick();
    chk("hold.flush", 64'(flush), 64'd1);
    chk("hold.redir_pc", redir_pc, 64'h1004);
    apply(2'd1, 64'h7000, 64'h100, 64'h0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("hold%0d.flush", c), 64'(flush), 64'd0);
      chk($sformatf("hold%0d.redir_valid", c), 64'(redir_valid), 64'd1);
      chk($sformatf("hold%0d.redir_pc", c), redir_pc, 64'h1004);
      chk($sformatf("hold%0d.ex_ready", c), 64'(ex_ready), 64'd0);
      chk($sformatf("hold%0d.res_valid", c), 64'(res_valid), 64'd0);
    end
    redir_ready = 1'b1;
    tick();
    redir_ready = 1'b0;
    chk("hold.handshake_valid", 64'(redir_valid), 64'd0);
    chk("hold.handshake_ready", 64'(ex_ready), 64'd1);
    chk("hold.no_accept_in_M", 64'(res_valid), 64'd0);
    ex_valid = 1'b0;
    tick();

    // async reset during HOLD
    apply(2'd2, 64'h3000, 64'h10, 64'h2003, 1'b0, 1'b1);
    tick();
    ex_valid = 1'b0;
    chk("rsthold.redir_valid_pre", 64'(redir_valid), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rsthold.redir_valid", 64'(redir_valid), 64'd0);
    chk("rsthold.ex_ready", 64'(ex_ready), 64'd1);
    chk("rsthold.res_valid", 64'(res_valid), 64'd0);
    chk("rsthold.stat_branches", 64'(stat_branches), 64'd0);
    chk("rsthold.stat_mispred", 64'(stat_mispred), 64'd0);
    #3;
    rstn = 1'b1;
    tick();
    chk("rsthold.after_ready", 64'(ex_ready), 64'd1);
    chk("rsthold.after_redir", 64'(redir_valid), 64'd0);

    // 5 accepts, 2 mispredicted, one ex_valid pulse during HOLD
    apply(2'd0, 64'h100, 64'h10, 64'h0, 1'b1, 1'b1);
    tick();
    apply(2'd0, 64'h100, 64'h10, 64'h0, 1'b0, 1'b1);
    tick();
    apply(2'd0, 64'h900, 64'h10, 64'h0, 1'b1, 1'b1);
    tick();
    ex_valid = 1'b0;
    handshake("st.h1");
    apply(2'd1, 64'h200, 64'h10, 64'h0, 1'b0, 1'b1);
    tick();
    apply(2'd0, 64'h300, 64'h10, 64'h0, 1'b0, 1'b0);
    tick();
    apply(2'd2, 64'h400, 64'h10, 64'h80, 1'b0, 1'b1);
    tick();
    ex_valid = 1'b0;
    handshake("st.h2");
`ifdef BRANCH_STATS_EN
    chk("stats.branches", 64'(stat_branches), 64'd5);
    chk("stats.mispred", 64'(stat_mispred), 64'd2);
`else
    chk("stats.branches_off", 64'(stat_branches), 64'd0);
    chk("stats.mispred_off", 64'(stat_mispred), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

- Resolves control-flow instructions in EX, one cycle after the comparator produces `cmp_res`.
- Computes the taken/not-taken outcome, the target and the link value.
- On a misprediction, raises a redirect to fetch and holds it until fetch accepts it, stalling further branch issue meanwhile.
- Sits directly downstream of the branch comparator, between EX and the fetch redirect port.

## Interface

Parameters:
- `XLEN`, 64, datapath width.
- `CNT_W`, 32, statistics counter width (only with `BRANCH_STATS_EN`).

Ports:
- `clk` in 1: core clock.
- `rstn` in 1: reset, asynchronous and active-low.
- `ex_valid` in 1: EX presents a control-flow instruction.
- `ex_ready` out 1: unit can accept.
- `ex_kind` in 2: 00 BR, 01 JAL, 10 JALR, 11 reserved.
- `ex_pc` in XLEN: instruction PC.
- `ex_imm` in XLEN: sign-extended immediate.
- `ex_rs1` in XLEN: rs1 value (JALR).
- `cmp_res` in 1: comparator result for BR.
- `ex_pred_taken` in 1: fetch's prediction for this instruction.
- `res_valid` out 1: one-cycle result pulse.
- `res_taken` out 1: resolved direction.
- `link_data` out XLEN: pc+4 for JAL/JALR, 0 for BR.
- `flush` out 1: one-cycle pulse, kill younger instructions.
- `redir_valid` out 1: redirect request.
- `redir_pc` out XLEN: redirect target.
- `redir_ready` in 1: fetch accepts redirect.
- `stat_branches` out CNT_W: resolved instruction count (stats only).
- `stat_mispred` out CNT_W: misprediction count (stats only).

## Operation

Accept rule:
- An instruction is accepted when `ex_valid && ex_ready`.

Outcome (computed combinationally at accept):
- taken: BR = `cmp_res`; JAL/JALR = 1; reserved = 0.
- target: BR/JAL = `ex_pc + ex_imm`; JALR = `(ex_rs1 + ex_imm) & ~1`.
- next = taken ? target : `ex_pc + 4`.
- All sums are modulo 2^XLEN; wrap-around is silent.
- No alignment check beyond JALR bit0 clear.

Misprediction:
- mispredict = `(taken != ex_pred_taken) || kind == JALR`.
- JALR always redirects.
- Reserved kind never mispredicts unless `ex_pred_taken`=1.

State machine:
- IDLE: `ex_ready`=1.
  - Accept without mispredict: stay IDLE.
  - Accept with mispredict: go to HOLD.
- HOLD: `ex_ready`=0, `redir_valid`=1.
  - Go to IDLE on `redir_valid && redir_ready`.
  - Otherwise hold `redir_pc` stable.

Registered outputs (cycle after accept):
- `res_valid`=1, `res_taken`, `link_data`.
- On mispredict also: `flush`=1 (one cycle only, even if HOLD lasts longer), `redir_valid`=1, `redir_pc`=next.

Boundary cases:
- `ex_valid` in HOLD is ignored; not accepted, not counted.
- `redir_ready` high while not in HOLD has no effect.
- Reset mid-HOLD returns to IDLE, drops the redirect, and discards the in-flight result.

## Timing

- Latency: accept at cycle N → `res_valid`/`flush`/`redir_valid` at N+1.
- Back-to-back correctly predicted instructions: one per cycle.
- Redirect handshake at cycle M:
  - `redir_valid`=0 and `ex_ready`=1 at M+1.
  - No accept in cycle M.
- Minimum mispredict-to-next-accept: 2 cycles when `redir_ready` is tied high.
- Reset values: all outputs 0, except `ex_ready`=1. State IDLE, counters 0.

## Configuration

- `BRANCH_STATS_EN` defined:
  - `stat_branches` increments on every accept.
  - `stat_mispred` increments on every mispredicted accept.
  - Both saturate at 2^CNT_W−1 and reset to 0.
- Not defined: counters and their logic are absent; `stat_*` ports are driven 0.

## Test plan

- BR, pc=0x1000, imm=0x40, `cmp_res`=1, pred=1:
  - → N+1: `res_valid`=1, `res_taken`=1, `flush`=0, `redir_valid`=0.
- BR, pc=0x1000, imm=0x40, `cmp_res`=0, pred=1:
  - → `flush` pulse, `redir_pc`=0x1004.
  - `redir_ready` low 3 cycles: `redir_valid` and `redir_pc` held; `ex_ready`=0.
  - `ex_valid` ignored during the hold.
- JALR, rs1=0x2003, imm=0x10, pc=0x3000:
  - → `redir_pc`=0x2012, `link_data`=0x3004, `res_taken`=1.
- JAL, pc=0xFFFF_FFFF_FFFF_FFFC, imm=8, pred=0:
  - → `redir_pc`=0x4, `link_data`=0x0 (wrap).
- Async `rstn` low during HOLD:
  - → `redir_valid`=0 and `ex_ready`=1 immediately.
  - With `BRANCH_STATS_EN`, counters = 0.
- `BRANCH_STATS_EN`, 5 branches, 2 mispredicted, one `ex_valid` pulse during HOLD:
  - → `stat_branches`=5, `stat_mispred`=2.
